line_assembler: RTL and testbench

LINE_ASSEMBLER -- requirements
Module: line_assembler

---
 rtl/line_assembler.sv | 139 +++++++++++++
 tb/tb_line_assembler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_assembler.sv
// line_assembler -- gathers up to 16 words of `width` bits into one line
// and hands the line to a consumer with a valid/ready handshake.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready word handshake; in_sel picks slot, in_data is the word
//   flush             hand off a partially filled line (LINE_ASSEMBLER_FLUSH_EN)
//   out_valid/out_ready line handshake
//   out_line          16 slots, slot k at [k*width +: width]; unwritten slots read 0
//   out_mask          bit k set when slot k was written
//   out_count         popcount of out_mask (0..16)
//
// Build option
//   LINE_ASSEMBLER_FLUSH_EN  when defined, flush in FILL with a non-empty line
//                            (counting a same-cycle write) moves to HOLD.
//                            When undefined, flush is ignored entirely.

// One storage slot: cleared when the line is accepted, loaded on a write.
module line_assembler_slot #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (we)
            q <= d;
    end
endmodule

module line_assembler #(
    parameter int width = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [3:0]          in_sel,
    input  logic [width-1:0]    in_data,
    output logic                in_ready,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*width-1:0] out_line,
    output logic [15:0]         out_mask,
    output logic [4:0]          out_count
);
    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t                  state, state_nxt;
    logic                    wr;
    logic                    clr;
    logic                    flush_go;
    logic [15:0]             sel_oh;
    logic [15:0]             mask_q;
    logic [15:0]             mask_nxt;
    logic [4:0]              count_q;
    logic [15:0][width-1:0]  slot_q;

    // Writes only land in FILL; HOLD ignores the producer side completely.
    assign wr       = (state == FILL) && in_valid;
    assign clr      = (state == HOLD) && out_ready;
    assign sel_oh   = 16'd1 << in_sel;
    assign mask_nxt = wr ? (mask_q | sel_oh) : mask_q;

`ifdef LINE_ASSEMBLER_FLUSH_EN
    // mask_nxt already includes a write in the same cycle as the flush.
    assign flush_go = flush && (mask_nxt != 16'd0);
`else
    logic flush_unused;
    assign flush_unused = flush;
    assign flush_go     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FILL;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if ((&mask_nxt) || flush_go) state_nxt = HOLD;
            HOLD: if (out_ready)               state_nxt = FILL;
            default:                           state_nxt = FILL;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            FILL:    in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: in_ready  = 1'b1;
        endcase
    end

    // Mask and count move together; a rewrite of a set slot adds nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q  <= '0;
            count_q <= '0;
        end else if (clr) begin
            mask_q  <= '0;
            count_q <= '0;
        end else if (wr) begin
            mask_q  <= mask_nxt;
            count_q <= count_q + {4'd0, ~mask_q[in_sel]};
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_slot
        line_assembler_slot #(.width(width)) u_slot (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .we  (wr && sel_oh[k]),
            .d   (in_data),
            .q   (slot_q[k])
        );
    end

    assign out_line  = slot_q;
    assign out_mask  = mask_q;
    assign out_count = count_q;
endmodule

// File: tb/tb_line_assembler.sv
module tb_line_assembler;
    localparam int W  = 16;
    localparam int VW = 1 + 1 + 5 + 16 + 16 * W;
`ifdef LINE_ASSEMBLER_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [3:0]      in_sel = '0;
    logic [W-1:0]    in_data = '0;
    logic            in_ready;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [16*W-1:0] out_line;
    logic [15:0]     out_mask;
    logic [4:0]      out_count;

    int passed = 0;
    int total  = 0;

    // Reference model: a line is a set of written slots plus a "holding" flag.
    logic [W-1:0] m_data [16];
    bit           m_wr   [16];
    bit           holding;

    line_assembler #(.width(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel),
        .in_data(in_data), .in_ready(in_ready), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_line(out_line),
        .out_mask(out_mask), .out_count(out_count)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        int n = 0;
        for (int k = 0; k < 16; k++) n += m_wr[k] ? 1 : 0;
        return n;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 16; k++) begin
            m_data[k] = '0;
            m_wr[k]   = 1'b0;
        end
        holding = 1'b0;
    endfunction

    // Applies one clock edge to the model using the inputs currently driven.
    function automatic void m_edge();
        if (!holding) begin
            if (in_valid) begin
                m_data[in_sel] = in_data;
                m_wr[in_sel]   = 1'b1;
            end
            if (m_count() == 16)
                holding = 1'b1;
            else if (FLUSH_EN && flush && m_count() > 0)
                holding = 1'b1;
        end else if (out_ready) begin
            m_reset();
        end
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [16*W-1:0] line = '0;
        logic [15:0]     m    = '0;
        for (int k = 0; k < 16; k++) begin
            m[k] = m_wr[k];
            if (m_wr[k]) line[k*W +: W] = m_data[k];
        end
        return {holding, ~holding, 5'(m_count()), m, line};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {out_valid, in_ready, out_count, out_mask, out_line};
    endfunction

    // Drive one cycle of inputs, advance DUT and model by one edge, settle.
    task automatic drive(input bit v, input logic [3:0] s, input logic [W-1:0] d,
                         input bit fl, input bit ordy);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic test_reset();
        m_reset();
        #1;
        total++;
        if (dut_vec() !== exp_vec())
            $display("FAIL reset_async got=%h exp=%h", dut_vec(), exp_vec());
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_count !== 5'd0 || out_mask !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_line !== '0)
            $display("FAIL reset_held cnt=%0d mask=%h v=%b r=%b exp cnt=0 mask=0 v=0 r=1", out_count, out_mask, out_valid, in_ready);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_line();
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 4'(k), 16'h1000 + 16'(k), 1'b0, 1'b0);
            total++;
            if (out_valid !== (k == 15))
                $display("FAIL full_valid slot=%0d got=%b exp=%b", k, out_valid, (k == 15));
            else passed++;
        end
        total++;
        if (out_mask !== 16'hFFFF || out_count !== 5'd16)
            $display("FAIL full_mask got mask=%h cnt=%0d exp mask=ffff cnt=16", out_mask, out_count);
        else passed++;
        for (int k = 0; k < 16; k++) begin
            total++;
            if (out_line[k*W +: W] !== 16'h1000 + 16'(k))
                $display("FAIL full_slot%0d got=%h exp=%h", k, out_line[k*W +: W], 16'h1000 + 16'(k));
            else passed++;
        end
    endtask

    task automatic test_hold();
        logic [16*W-1:0] held;
        held = out_line;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'(i), 16'hDEAD, 1'b1, 1'b0);
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_line !== held || dut_vec() !== exp_vec())
                $display("FAIL hold_stable cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            else passed++;
        end
        drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
        total++;
        if (out_valid !== 1'b0 || out_count !== 5'd0 || in_ready !== 1'b1 || out_line !== '0)
            $display("FAIL hold_accept v=%b cnt=%0d r=%b exp v=0 cnt=0 r=1", out_valid, out_count, in_ready);
        else passed++;
    endtask

    task automatic test_rewrite();
        drive(1'b1, 4'd3, 16'hAAAA, 1'b0, 1'b0);
        drive(1'b1, 4'd3, 16'h5555, 1'b0, 1'b0);
        total++;
        if (out_count !== 5'd1 || out_mask !== 16'h0008)
            $display("FAIL rewrite_count got cnt=%0d mask=%h exp cnt=1 mask=0008", out_count, out_mask);
        else passed++;
        for (int k = 0; k < 16; k++)
            if (k != 3) drive(1'b1, 4'(k), 16'($urandom), 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_line[3*W +: W] !== 16'h5555 || dut_vec() !== exp_vec())
            $display("FAIL rewrite_handoff got slot3=%h v=%b exp slot3=5555 v=1", out_line[3*W +: W], out_valid);
        else passed++;
        drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        drive(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);   // flush with empty mask
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 5'd0)
            $display("FAIL flush_empty got v=%b r=%b cnt=%0d exp v=0 r=1 cnt=0", out_valid, in_ready, out_count);
        else passed++;
        drive(1'b1, 4'd2, 16'h0202, 1'b0, 1'b0);
        drive(1'b1, 4'd7, 16'h0707, 1'b0, 1'b0);
        drive(1'b1, 4'd9, 16'h0909, 1'b1, 1'b0);
        total++;
        if (out_valid !== FLUSH_EN || out_mask !== 16'h0284 || out_count !== 5'd3 || dut_vec() !== exp_vec())
            $display("FAIL flush_partial got v=%b mask=%h cnt=%0d exp v=%b mask=0284 cnt=3", out_valid, out_mask, out_count, FLUSH_EN);
        else passed++;
        // Finish whatever line is open so the next test starts in FILL.
        for (int k = 0; k < 16; k++)
            if (!holding && !m_wr[k]) drive(1'b1, 4'(k), 16'($urandom), 1'b0, 1'b0);
        drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
        total++;
        if (dut_vec() !== exp_vec())
            $display("FAIL flush_drain got=%h exp=%h", dut_vec(), exp_vec());
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, 4'($urandom), 16'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4);
            total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            else passed++;
        end
        // Leave in a known empty FILL state.
        while (holding || m_count() != 0) begin
            if (holding) drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
            else begin
                for (int k = 0; k < 16; k++)
                    if (!holding && !m_wr[k]) drive(1'b1, 4'(k), 16'($urandom), 1'b0, 1'b0);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 8; k++) drive(1'b1, 4'(k), 16'hBEE0 + 16'(k), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        m_reset();
        #1;
        total++;
        if (out_count !== 5'd0 || out_mask !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_line !== '0)
            $display("FAIL areset_partial got cnt=%0d mask=%h v=%b r=%b exp cnt=0 mask=0 v=0 r=1", out_count, out_mask, out_valid, in_ready);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) drive(1'b1, 4'(15 - k), 16'hC000 + 16'(k), 1'b0, 1'b0);
        total++;
        if (dut_vec() !== exp_vec() || out_line[0 +: W] !== 16'hC00F)
            $display("FAIL areset_refill got=%h exp=%h", dut_vec(), exp_vec());
        else passed++;
        // Reset while holding: line is discarded, never presented again.
        #2 rst = 1'b1;
        m_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 5'd0 || out_line !== '0)
            $display("FAIL areset_hold got v=%b r=%b cnt=%0d exp v=0 r=1 cnt=0", out_valid, in_ready, out_count);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
        total++;
        if (dut_vec() !== exp_vec())
            $display("FAIL areset_after got=%h exp=%h", dut_vec(), exp_vec());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_hold();
        test_rewrite();
        test_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
